instruction_fetch_queue: RTL

Decoupled instruction fetch stage sitting upstream of the single-cycle RISC-V datapath. It owns the fetch PC and issues sequential 4-byte fetches to a variable-latency instruction memory over a req/ack handshake. Fetched {PC, instruction} pairs are buffered in a small FIFO and presented to the decode stage (instruction parser, control unit, immediate extractor) over valid/ready. Branch/jump redirects from execute flush the queue and restart fetch.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/instruction_fetch_queue.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned INST_W = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Instruction fetches are always word aligned.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return {pc[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO of {pc, inst} pairs with flush; head is read from registered storage.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             head_valid,
  output fetch_entry_t     head
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_d;
  logic             do_pop;

  assign do_pop = pop && (count != '0);

  // Flush wins over any same-cycle push or pop.
  always_comb begin
    count_d = count;
    if (flush) begin
      count_d = '0;
    end else if (push && !do_pop) begin
      count_d = count + CNT_W'(1);
    end else if (!push && do_pop) begin
      count_d = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count      <= '0;
      head_valid <= 1'b0;
    end else begin
      count      <= count_d;
      head_valid <= (count_d != '0);
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push && !flush) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch_queue.sv
// Decoupled fetch stage: owns the fetch PC, issues req/ack fetches and buffers results.
// Optional perf counters enabled by defining FETCH_QUEUE_PERF_EN.
module instruction_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'd0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t      state_q;
  fetch_state_t      state_d;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] fetch_pc_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [ADDR_W-1:0] redir_pc;
  logic [ADDR_W-1:0] next_pc;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  post_cnt;
  logic              push_c;
  logic              pop_c;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  assign pop_c      = inst_valid && inst_ready;
  assign redir_pc   = align_pc(redirect_pc);
  assign next_pc    = fetch_pc_q + PC_STEP;
  // Room was reserved at issue, so count + 1 never exceeds DEPTH here.
  assign post_cnt   = count + CNT_W'(1) - CNT_W'(pop_c);
  assign push_entry = '{pc: fetch_pc_q, inst: mem_rdata};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr;
    push_c     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          fetch_pc_d = redir_pc;
          mem_addr_d = redir_pc;
          state_d    = REQ;
        end else if (count < CNT_W'(DEPTH)) begin
          mem_addr_d = fetch_pc_q;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          fetch_pc_d = redir_pc;
          if (mem_ack) begin
            mem_addr_d = redir_pc;
          end else begin
            state_d = DROP;
          end
        end else if (mem_ack) begin
          push_c     = 1'b1;
          fetch_pc_d = next_pc;
          mem_addr_d = next_pc;
          if (post_cnt >= CNT_W'(DEPTH)) begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        // The outstanding fetch belongs to a squashed path; its data is never pushed.
        if (redirect_valid) begin
          fetch_pc_d = redir_pc;
        end
        if (mem_ack) begin
          mem_addr_d = redirect_valid ? redir_pc : fetch_pc_q;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req    <= 1'b0;
      mem_addr   <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req    <= (state_d != IDLE);
      mem_addr   <= mem_addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .push_entry(push_entry),
    .pop       (pop_c),
    .flush     (redirect_valid),
    .count     (count),
    .head_valid(inst_valid),
    .head      (head)
  );

  assign inst_data = head.inst;
  assign inst_pc   = head.pc;

`ifdef FETCH_QUEUE_PERF_EN
  // Saturating event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (inst_ready && !inst_valid && (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (redirect_valid && (perf_flush_cnt != '1)) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
